// File: rtl/fsm_seq_arbiter_pkg.sv
// Shared types, state encodings and helpers for the sequenced-FSM arbiter.
// The state encoding is kept as fixed constants so legacy tooling sees the same values.
package fsm_seq_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE  = 3'd0;
   localparam state_t CLEAR = 3'd1;
   localparam state_t FEED  = 3'd2;
   localparam state_t DRAIN = 3'd3;
   localparam state_t DONE  = 3'd4;

   localparam logic [1:0] HIT_STATE_DEF = 2'b11;

   typedef logic owner_t;

   // Single requester wins outright; on a tie the one that did not go last wins.
   function automatic owner_t rr_pick(input logic [1:0] req, input owner_t last_owner);
      owner_t pick;
      case (req)
         2'b01:   pick = 1'b0;
         2'b10:   pick = 1'b1;
         2'b11:   pick = ~last_owner;
         default: pick = ~last_owner;
      endcase
      return pick;
   endfunction

   function automatic logic [1:0] owner_onehot(input owner_t owner);
      return owner ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/fsm_seq_arbiter_if.sv
// Requester-side and FSM-side signals of the sequenced-FSM arbiter.
// master is the arbiter; slave is the environment (requesters plus the shared FSM).
interface fsm_seq_arbiter_if #(
   parameter int unsigned PAT_W = 16,
   parameter int unsigned CNT_W = 5
);

   logic [1:0]       req;
   logic [PAT_W-1:0] pat0;
   logic [PAT_W-1:0] pat1;
   logic [CNT_W-1:0] len0;
   logic [CNT_W-1:0] len1;
   logic [1:0]       gnt;
   logic             busy;
   logic [1:0]       done;
   logic [1:0]       res_state;
   logic [CNT_W-1:0] res_hits;
   logic             fsm_clr;
   logic             fsm_step;
   logic             fsm_inp;
   logic [1:0]       fsm_state;

   modport master (
      input  req, pat0, pat1, len0, len1, fsm_state,
      output gnt, busy, done, res_state, res_hits, fsm_clr, fsm_step, fsm_inp
   );

   modport slave (
      output req, pat0, pat1, len0, len1, fsm_state,
      input  gnt, busy, done, res_state, res_hits, fsm_clr, fsm_step, fsm_inp
   );

endinterface

// File: rtl/fsm_seq_arbiter_rr_arb2.sv
// Two-requester round-robin picker; remembers the last served owner.
// last_owner resets to 1 so requester 0 wins the first tie.
module rr_arb2
   import fsm_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       upd,
   input  owner_t     upd_owner,
   output owner_t     pick
);

   owner_t last_owner_q;
   owner_t last_owner_d;

   always_comb begin
      last_owner_d = last_owner_q;
      if (upd) begin
         last_owner_d = upd_owner;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_owner_q <= 1'b1;
      end else begin
         last_owner_q <= last_owner_d;
      end
   end

   assign pick = rr_pick(req, last_owner_q);

endmodule

// File: rtl/fsm_seq_arbiter.sv
// Grants the shared 2-bit FSM to one of two requesters, clears it, feeds the
// owner's pattern LSB-first and reports the final state plus hit count.
module fsm_seq_arbiter
   import fsm_seq_pkg::*;
#(
   parameter int unsigned PAT_W     = 16,
   parameter int unsigned CNT_W     = 5,
   parameter logic [1:0]  HIT_STATE = HIT_STATE_DEF
) (
   input logic               clk,
   input logic               rst,
   fsm_seq_arbiter_if.master bus
);

   state_t           state_q,     state_d;
   owner_t           owner_q,     owner_d;
   logic [PAT_W-1:0] shreg_q,     shreg_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [CNT_W-1:0] hits_q,      hits_d;
   logic             stepped_q,   stepped_d;
   logic [1:0]       res_state_q, res_state_d;
   logic [CNT_W-1:0] res_hits_q,  res_hits_d;

   owner_t           pick;
   logic [PAT_W-1:0] pat_sel;
   logic [CNT_W-1:0] len_sel;
   logic [CNT_W-1:0] len_clamped;
   logic [CNT_W-1:0] hits_sat;
   logic [CNT_W-1:0] hits_upd;
   logic             hit_now;

   rr_arb2 u_rr_arb2 (
      .clk       (clk),
      .rst       (rst),
      .req       (bus.req),
      .upd       (state_q == DONE),
      .upd_owner (owner_q),
      .pick      (pick)
   );

   assign pat_sel     = pick ? bus.pat1 : bus.pat0;
   assign len_sel     = pick ? bus.len1 : bus.len0;
   assign len_clamped = (len_sel > CNT_W'(PAT_W)) ? CNT_W'(PAT_W) : len_sel;

   // The FSM output lags each step by one cycle, hence the registered step flag.
   assign hit_now  = stepped_q && (bus.fsm_state == HIT_STATE);
   assign hits_sat = (&hits_q) ? hits_q : hits_q + CNT_W'(1);
   assign hits_upd = hit_now ? hits_sat : hits_q;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      hits_d      = hits_q;
      res_state_d = res_state_q;
      res_hits_d  = res_hits_q;
      stepped_d   = (state_q == FEED);

      case (state_q)
         IDLE: begin
            if (bus.req != 2'b00) begin
               owner_d = pick;
               shreg_d = pat_sel;
               cnt_d   = len_clamped;
               hits_d  = '0;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            state_d = (cnt_q != '0) ? FEED : DRAIN;
         end
         FEED: begin
            hits_d  = hits_upd;
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            hits_d      = hits_upd;
            res_state_d = bus.fsm_state;
            res_hits_d  = hits_upd;
            state_d     = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         shreg_q     <= '0;
         cnt_q       <= '0;
         hits_q      <= '0;
         stepped_q   <= 1'b0;
         res_state_q <= 2'b00;
         res_hits_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         hits_q      <= hits_d;
         stepped_q   <= stepped_d;
         res_state_q <= res_state_d;
         res_hits_q  <= res_hits_d;
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.gnt       = (state_q != IDLE) ? owner_onehot(owner_q) : 2'b00;
   assign bus.done      = (state_q == DONE) ? owner_onehot(owner_q) : 2'b00;
   assign bus.fsm_clr   = (state_q == CLEAR);
   assign bus.fsm_step  = (state_q == FEED);
   assign bus.fsm_inp   = (state_q == FEED) && shreg_q[0];
   assign bus.res_state = res_state_q;
   assign bus.res_hits  = res_hits_q;

endmodule

// File: tb/tb_fsm_seq_arbiter.sv
// Directed bench for fsm_seq_arbiter with a stub FSM (state += inp on each step).
module tb_fsm_seq_arbiter;

   logic clk;
   logic rst;

   int checks;
   int errors;
   int steps;
   int overlap;

   fsm_seq_arbiter_if #(.PAT_W(16), .CNT_W(5)) bus ();

   fsm_seq_arbiter #(
      .PAT_W     (16),
      .CNT_W     (5),
      .HIT_STATE (2'b11)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.fsm_state <= 2'b00;
      end else if (bus.fsm_clr) begin
         bus.fsm_state <= 2'b00;
      end else if (bus.fsm_step) begin
         bus.fsm_state <= bus.fsm_state + {1'b0, bus.fsm_inp};
      end
   end

   always @(posedge clk) begin
      if (bus.fsm_step) steps++;
      if (bus.fsm_step && bus.fsm_clr) overlap++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Starts from IDLE; sampling edge is edge 1, done expected after edge len+3.
   task automatic do_op(input logic [1:0] r, input int own, input int nsteps,
                        input logic [1:0] st, input int hits, input bit drop,
                        input string tag);
      int n;
      int gbad;
      logic [1:0] oh;
      oh = (own == 1) ? 2'b10 : 2'b01;
      steps = 0;
      gbad = 0;
      bus.req = r;
      @(posedge clk); #1;
      n = 1;
      while (bus.done == 2'b00 && n < 60) begin
         if (bus.gnt !== oh || bus.busy !== 1'b1) gbad++;
         if (drop && n == 4) bus.req = 2'b00;
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_latency"}, n, nsteps + 3);
      check({tag, "_done"}, {30'd0, bus.done}, {30'd0, oh});
      check({tag, "_gnt_at_done"}, {30'd0, bus.gnt}, {30'd0, oh});
      check({tag, "_gnt_held"}, gbad, 0);
      check({tag, "_res_state"}, {30'd0, bus.res_state}, {30'd0, st});
      check({tag, "_res_hits"}, {27'd0, bus.res_hits}, hits);
      check({tag, "_steps"}, steps, nsteps);
      @(posedge clk); #1;
      check({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_idle_gnt"}, {30'd0, bus.gnt}, 32'd0);
      check({tag, "_res_held"}, {30'd0, bus.res_state}, {30'd0, st});
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      steps   = 0;
      overlap = 0;
      rst      = 1'b0;
      bus.req  = 2'b00;
      bus.pat0 = '0;
      bus.pat1 = '0;
      bus.len0 = '0;
      bus.len1 = '0;
      #2;
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_gnt", {30'd0, bus.gnt}, 32'd0);
      check("rst_done", {30'd0, bus.done}, 32'd0);
      check("rst_clr_step", {30'd0, bus.fsm_clr, bus.fsm_step}, 32'd0);
      check("rst_res_hits", {27'd0, bus.res_hits}, 32'd0);
      #10 rst = 1'b1;
      @(posedge clk); #1;

      // Reset mid-FEED aborts immediately
      bus.pat0 = 16'h000F;
      bus.len0 = 5'd8;
      bus.req  = 2'b01;
      repeat (4) @(posedge clk);
      #1;
      check("mid_is_feeding", {31'd0, bus.fsm_step}, 32'd1);
      rst = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      check("mid_rst_gnt", {30'd0, bus.gnt}, 32'd0);
      check("mid_rst_done", {30'd0, bus.done}, 32'd0);
      check("mid_rst_fsm", {29'd0, bus.fsm_clr, bus.fsm_step, bus.fsm_inp}, 32'd0);
      check("mid_rst_res", {25'd0, bus.res_state, bus.res_hits}, 32'd0);
      bus.req = 2'b00;
      #3 rst = 1'b1;
      @(posedge clk); #1;
      check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

      // 000F len 4: 01,10,11,00
      bus.pat0 = 16'h000F;
      bus.len0 = 5'd4;
      do_op(2'b01, 0, 4, 2'b00, 1, 1'b0, "r0_len4");
      bus.req = 2'b00;

      // 0007 len 3: 01,10,11
      bus.pat1 = 16'h0007;
      bus.len1 = 5'd3;
      do_op(2'b10, 1, 3, 2'b11, 1, 1'b0, "r1_len3");
      bus.req = 2'b00;

      // Tie held: alternate 0,1,0,1
      bus.pat0 = 16'h0003;
      bus.pat1 = 16'h0002;
      bus.len0 = 5'd2;
      bus.len1 = 5'd2;
      do_op(2'b11, 0, 2, 2'b10, 0, 1'b0, "alt_a0");
      do_op(2'b11, 1, 2, 2'b01, 0, 1'b0, "alt_a1");
      do_op(2'b11, 0, 2, 2'b10, 0, 1'b0, "alt_b0");
      do_op(2'b11, 1, 2, 2'b01, 0, 1'b0, "alt_b1");
      bus.req = 2'b00;

      // Zero length
      bus.pat0 = 16'hFFFF;
      bus.len0 = 5'd0;
      do_op(2'b01, 0, 0, 2'b00, 0, 1'b0, "len0");
      bus.req = 2'b00;

      // Length clamped to 16
      bus.len0 = 5'd31;
      do_op(2'b01, 0, 16, 2'b00, 4, 1'b0, "clamp31");
      bus.req = 2'b00;

      // Full pattern, request dropped mid-FEED
      bus.len0 = 5'd16;
      do_op(2'b01, 0, 16, 2'b00, 4, 1'b1, "drop_mid");
      bus.req = 2'b00;

      check("clr_step_overlap", overlap, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
